// File: rtl/seg7_pkg.sv
// Shared 7-segment pattern constants and decode helper, common to the display
// driver and the capture front-end.
package seg7_pkg;

   localparam int unsigned SEG_W      = 7;
   localparam int unsigned NIB_W      = 4;
   localparam int unsigned NUM_DIGITS = 4;

   localparam int unsigned DIG_0 = 0;
   localparam int unsigned DIG_1 = 1;
   localparam int unsigned DIG_2 = 2;
   localparam int unsigned DIG_3 = 3;

   // Active-low patterns, bit order g..a
   localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
   localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
   localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
   localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
   localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
   localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
   localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
   localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
   localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
   localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
   localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
   localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
   localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
   localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
   localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
   localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
   localparam logic [SEG_W-1:0] SEG_MINUS = 7'b0111111;

   typedef struct packed {
      logic             valid;
      logic [NIB_W-1:0] nibble;
   } seg_dec_t;

   // Pattern to {valid, nibble}; anything outside the hex table is invalid
   function automatic seg_dec_t seg_decode(input logic [SEG_W-1:0] pat);
      seg_dec_t r;
      r.valid = 1'b1;
      case (pat)
         SEG_0:   r.nibble = 4'h0;
         SEG_1:   r.nibble = 4'h1;
         SEG_2:   r.nibble = 4'h2;
         SEG_3:   r.nibble = 4'h3;
         SEG_4:   r.nibble = 4'h4;
         SEG_5:   r.nibble = 4'h5;
         SEG_6:   r.nibble = 4'h6;
         SEG_7:   r.nibble = 4'h7;
         SEG_8:   r.nibble = 4'h8;
         SEG_9:   r.nibble = 4'h9;
         SEG_A:   r.nibble = 4'hA;
         SEG_B:   r.nibble = 4'hB;
         SEG_C:   r.nibble = 4'hC;
         SEG_D:   r.nibble = 4'hD;
         SEG_E:   r.nibble = 4'hE;
         SEG_F:   r.nibble = 4'hF;
         default: begin
            r.valid  = 1'b0;
            r.nibble = 4'h0;
         end
      endcase
      return r;
   endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational segment pattern decoder: {valid, is_minus, nibble}.
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [SEG_W-1:0] seg,
   output logic             valid_c,
   output logic             is_minus_c,
   output logic [NIB_W-1:0] nibble_c
);

   seg_dec_t dec;

   always_comb begin
      dec        = seg_decode(seg);
      valid_c    = dec.valid;
      nibble_c   = dec.nibble;
      is_minus_c = (seg == SEG_MINUS);
   end

endmodule

// File: rtl/seg7_capture.sv
// Captures a multiplexed 7-segment display bus and reassembles four-digit
// frames with sign, pattern/select error flags and a stale-bus timer.
module seg7_capture
   import seg7_pkg::*;
#(
   parameter int unsigned TIMEOUT = 1000000,
   parameter int unsigned CNT_W   = 20
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic [SEG_W-1:0]      seg_in,
   input  logic [NUM_DIGITS-1:0] dig_en,
   input  logic                  stb,
   output logic [NIB_W-1:0]      d0,
   output logic [NIB_W-1:0]      d1,
   output logic [NIB_W-1:0]      d2,
   output logic [NIB_W-1:0]      d3,
   output logic                  sinal,
   output logic                  frame_valid,
   output logic                  pat_err,
   output logic                  sel_err,
   output logic                  stale
);

   localparam int unsigned IDX_W = 2;

   logic                                 dec_valid;
   logic                                 dec_minus;
   logic [NIB_W-1:0]                     dec_nib;

   logic [NUM_DIGITS-1:0][NIB_W-1:0]     shadow_q, shadow_n;
   logic [NUM_DIGITS-1:0]                seen_q, seen_n;
   logic [NUM_DIGITS-1:0]                err_q, err_n;
   logic                                 sign_q, sign_n;
   logic [CNT_W-1:0]                     cnt_q, cnt_n;
   logic                                 phase_q, phase_n;

   logic [NUM_DIGITS-1:0]                sel;
   logic                                 one_hot;
   logic                                 accept;
   logic                                 commit;
   logic [IDX_W-1:0]                     idx;

   seg7_decode u_decode (
      .seg        (seg_in),
      .valid_c    (dec_valid),
      .is_minus_c (dec_minus),
      .nibble_c   (dec_nib)
   );

   // Shadow frame update, commit detect and stale timer next-state
   always_comb begin
      shadow_n = shadow_q;
      seen_n   = seen_q;
      err_n    = err_q;
      sign_n   = sign_q;
      cnt_n    = cnt_q;
      phase_n  = ~phase_q;
      idx      = '0;

      sel     = ~dig_en;
      one_hot = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
      accept  = stb && one_hot;
      for (int i = 0; i < int'(NUM_DIGITS); i++) begin
         if (sel[i]) idx = IDX_W'(i);
      end

      if (accept) begin
         seen_n[idx] = 1'b1;
         if (idx == IDX_W'(DIG_1) && dec_minus) begin
            shadow_n[idx] = '0;
            err_n[idx]    = 1'b0;
            sign_n        = 1'b1;
         end else begin
            shadow_n[idx] = dec_valid ? dec_nib : '0;
            err_n[idx]    = ~dec_valid;
            if (idx == IDX_W'(DIG_1)) sign_n = 1'b0;
         end
      end

      commit = (seen_n == '1);

      // Counter advances on every second cycle and parks at TIMEOUT
      if (commit) begin
         cnt_n   = '0;
         phase_n = 1'b0;
      end else if (phase_q && cnt_q != CNT_W'(TIMEOUT)) begin
         cnt_n = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shadow_q    <= '0;
         seen_q      <= '0;
         err_q       <= '0;
         sign_q      <= 1'b0;
         cnt_q       <= '0;
         phase_q     <= 1'b0;
         d0          <= '0;
         d1          <= '0;
         d2          <= '0;
         d3          <= '0;
         sinal       <= 1'b0;
         frame_valid <= 1'b0;
         pat_err     <= 1'b0;
         sel_err     <= 1'b0;
         stale       <= 1'b0;
      end else begin
         shadow_q    <= shadow_n;
         seen_q      <= commit ? '0 : seen_n;
         err_q       <= commit ? '0 : err_n;
         sign_q      <= commit ? 1'b0 : sign_n;
         cnt_q       <= cnt_n;
         phase_q     <= phase_n;
         frame_valid <= commit;
         stale       <= (cnt_n == CNT_W'(TIMEOUT));
         if (commit) begin
            d0      <= shadow_n[DIG_0];
            d1      <= shadow_n[DIG_1];
            d2      <= shadow_n[DIG_2];
            d3      <= shadow_n[DIG_3];
            sinal   <= sign_n;
            pat_err <= |err_n;
         end
         if (stb && !one_hot) sel_err <= 1'b1;
      end
   end

endmodule

// File: tb/tb_seg7_capture.sv
// Randomized self-checking bench for seg7_capture with a frame-level model.
module tb_seg7_capture;

   localparam int unsigned TO = 8;
   localparam logic [6:0] MINUS = 7'b0111111;
   localparam logic [6:0] BLANK = 7'b1111111;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] seg_in = 7'h7F;
   logic [3:0] dig_en = 4'hF;
   logic       stb = 1'b0;
   logic [3:0] d0, d1, d2, d3;
   logic       sinal, frame_valid, pat_err, sel_err, stale;

   seg7_capture #(.TIMEOUT(TO), .CNT_W(4)) dut (
      .clk(clk), .rst(rst), .seg_in(seg_in), .dig_en(dig_en), .stb(stb),
      .d0(d0), .d1(d1), .d2(d2), .d3(d3), .sinal(sinal),
      .frame_valid(frame_valid), .pat_err(pat_err), .sel_err(sel_err), .stale(stale)
   );

   always #5 clk = ~clk;

   logic [3:0] dut_d [4];
   assign dut_d[0] = d0;
   assign dut_d[1] = d1;
   assign dut_d[2] = d2;
   assign dut_d[3] = d3;

   // Hex patterns in value order, written straight from the display table
   logic [6:0] pat_tab [16] = '{
      7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
      7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
      7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
      7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110 };

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   int   m_val [4];
   bit   m_seen [4];
   bit   m_err [4];
   bit   m_sign;
   bit   m_sel_err;
   logic [3:0] exp_d [4];
   bit   exp_sign;
   bit   exp_perr;

   function automatic logic [3:0] den_of(input int i);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << i);
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         m_val[i] = 0; m_seen[i] = 0; m_err[i] = 0; exp_d[i] = 4'h0;
      end
      m_sign = 0; m_sel_err = 0; exp_sign = 0; exp_perr = 0;
   endtask

   task automatic model_sample(input logic [6:0] seg, input logic [3:0] den, output bit commit);
      int zeros, di, v;
      bit all;
      commit = 0; zeros = 0; di = 0; v = -1;
      for (int i = 0; i < 4; i++) if (den[i] == 1'b0) begin zeros++; di = i; end
      if (zeros != 1) begin m_sel_err = 1; return; end
      for (int k = 0; k < 16; k++) if (pat_tab[k] == seg) v = k;
      if (di == 1 && seg == MINUS) begin
         m_val[1] = 0; m_err[1] = 0; m_sign = 1;
      end else begin
         m_val[di] = (v < 0) ? 0 : v;
         m_err[di] = (v < 0);
         if (di == 1) m_sign = 0;
      end
      m_seen[di] = 1;
      all = m_seen[0] && m_seen[1] && m_seen[2] && m_seen[3];
      if (all) begin
         commit = 1;
         exp_perr = 0;
         for (int i = 0; i < 4; i++) begin
            exp_d[i] = 4'(m_val[i]);
            exp_perr = exp_perr | m_err[i];
            m_seen[i] = 0; m_err[i] = 0;
         end
         exp_sign = m_sign;
         m_sign = 0;
      end
   endtask

   // Called at a negedge; returns at the negedge after the capturing posedge
   task automatic send(input logic [6:0] seg, input logic [3:0] den, output bit commit);
      model_sample(seg, den, commit);
      seg_in = seg; dig_en = den; stb = 1'b1;
      @(negedge clk);
      stb = 1'b0; dig_en = 4'hF; seg_in = 7'h7F;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (dut_d[i] !== 4'h0) begin n_fail++; $display("FAIL reset_d%0d got %h want 0", i, dut_d[i]); end
      end
      n_checks++;
      if ({sinal, frame_valid, pat_err, sel_err, stale} !== 5'b0) begin
         n_fail++; $display("FAIL reset_flags got %b want 00000", {sinal, frame_valid, pat_err, sel_err, stale});
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_basic();
      bit c;
      for (int i = 0; i < 4; i++) send(pat_tab[i + 1], den_of(i), c);
      n_checks++;
      if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL basic_fv got %b want 1", frame_valid); end
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if (dut_d[i] !== 4'(i + 1)) begin n_fail++; $display("FAIL basic_d%0d got %h want %h", i, dut_d[i], 4'(i + 1)); end
      end
      n_checks++;
      if ({sinal, pat_err} !== 2'b00) begin n_fail++; $display("FAIL basic_flags got %b want 00", {sinal, pat_err}); end
      @(negedge clk);
      n_checks++;
      if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL basic_fv_pulse got %b want 0", frame_valid); end
   endtask

   task automatic test_sign();
      bit c;
      send(pat_tab[9], den_of(0), c);
      send(MINUS, den_of(1), c);
      send(pat_tab[10], den_of(2), c);
      send(pat_tab[15], den_of(3), c);
      n_checks++;
      if ({frame_valid, sinal, pat_err} !== 3'b110) begin
         n_fail++; $display("FAIL sign_flags got %b want 110", {frame_valid, sinal, pat_err});
      end
      n_checks++;
      if ({d3, d2, d1, d0} !== 16'hFA09) begin n_fail++; $display("FAIL sign_digits got %h want FA09", {d3, d2, d1, d0}); end
      send(pat_tab[1], den_of(0), c);
      send(pat_tab[5], den_of(1), c);
      send(pat_tab[2], den_of(2), c);
      send(pat_tab[3], den_of(3), c);
      n_checks++;
      if ({frame_valid, sinal, d1} !== 6'b10_0101) begin
         n_fail++; $display("FAIL sign_clear got %b want 100101", {frame_valid, sinal, d1});
      end
   endtask

   task automatic test_pat_err();
      bit c;
      send(pat_tab[7], den_of(0), c);
      send(pat_tab[8], den_of(1), c);
      send(BLANK, den_of(2), c);
      send(pat_tab[6], den_of(3), c);
      n_checks++;
      if ({frame_valid, pat_err, d2} !== 6'b11_0000) begin
         n_fail++; $display("FAIL perr_set got %b want 110000", {frame_valid, pat_err, d2});
      end
      for (int i = 0; i < 4; i++) send(pat_tab[12 + i], den_of(i), c);
      n_checks++;
      if ({frame_valid, pat_err, d3, d2, d1, d0} !== {2'b10, 16'hFEDC}) begin
         n_fail++; $display("FAIL perr_clear got %h want 2fedc", {frame_valid, pat_err, d3, d2, d1, d0});
      end
   endtask

   task automatic test_overwrite_sel();
      bit c;
      send(pat_tab[3], den_of(0), c);
      send(pat_tab[7], den_of(0), c);
      send(pat_tab[0], den_of(1), c);
      send(pat_tab[0], den_of(2), c);
      n_checks++;
      if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL ovw_early_commit got %b want 0", frame_valid); end
      send(pat_tab[0], den_of(3), c);
      n_checks++;
      if ({frame_valid, d0, pat_err} !== 6'b1_0111_0) begin
         n_fail++; $display("FAIL ovw_commit got %b want 101110", {frame_valid, d0, pat_err});
      end
      send(pat_tab[2], 4'b1100, c);
      n_checks++;
      if ({sel_err, frame_valid} !== 2'b10) begin n_fail++; $display("FAIL sel_set got %b want 10", {sel_err, frame_valid}); end
      for (int i = 0; i < 4; i++) send(pat_tab[4], den_of(i), c);
      n_checks++;
      if ({sel_err, frame_valid, d3, d2, d1, d0} !== {2'b11, 16'h4444}) begin
         n_fail++; $display("FAIL sel_sticky got %h want 34444", {sel_err, frame_valid, d3, d2, d1, d0});
      end
   endtask

   task automatic test_stale();
      bit c;
      for (int i = 0; i < 4; i++) send(pat_tab[8], den_of(i), c);
      n_checks++;
      if ({frame_valid, stale} !== 2'b10) begin n_fail++; $display("FAIL stale_commit got %b want 10", {frame_valid, stale}); end
      repeat (3) @(negedge clk);
      n_checks++;
      if (stale !== 1'b0) begin n_fail++; $display("FAIL stale_early got %b want 0", stale); end
      repeat (2 * TO + 2) @(negedge clk);
      n_checks++;
      if (stale !== 1'b1) begin n_fail++; $display("FAIL stale_set got %b want 1", stale); end
      for (int i = 0; i < 3; i++) send(pat_tab[1], den_of(i), c);
      n_checks++;
      if (stale !== 1'b1) begin n_fail++; $display("FAIL stale_hold got %b want 1", stale); end
      send(pat_tab[1], den_of(3), c);
      n_checks++;
      if ({frame_valid, stale} !== 2'b10) begin n_fail++; $display("FAIL stale_clear got %b want 10", {frame_valid, stale}); end
   endtask

   task automatic test_reset_mid();
      bit c;
      send(pat_tab[5], den_of(0), c);
      send(pat_tab[6], den_of(1), c);
      rst = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if ({d3, d2, d1, d0, sinal, frame_valid, pat_err, sel_err, stale} !== 21'b0) begin
         n_fail++; $display("FAIL rstmid_outputs got %h want 0", {d3, d2, d1, d0, sinal, frame_valid, pat_err, sel_err, stale});
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(pat_tab[2], den_of(2), c);
      send(pat_tab[3], den_of(3), c);
      n_checks++;
      if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_commit got %b want 0", frame_valid); end
      send(pat_tab[0], den_of(0), c);
      send(pat_tab[1], den_of(1), c);
      n_checks++;
      if ({frame_valid, d3, d2, d1, d0} !== {1'b1, 16'h3210}) begin
         n_fail++; $display("FAIL rstmid_commit got %h want 13210", {frame_valid, d3, d2, d1, d0});
      end
   endtask

   task automatic test_random();
      bit c;
      logic [6:0] seg;
      logic [3:0] den;
      logic [3:0] bad_den [5] = '{4'b1111, 4'b1100, 4'b0000, 4'b1010, 4'b0101};
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 11) == 0) den = bad_den[$urandom_range(0, 4)];
         else den = den_of(int'($urandom_range(0, 3)));
         case ($urandom_range(0, 9))
            0:       seg = MINUS;
            1:       seg = 7'($urandom);
            default: seg = pat_tab[$urandom_range(0, 15)];
         endcase
         send(seg, den, c);
         n_checks++;
         if (frame_valid !== c) begin n_fail++; $display("FAIL rand_fv n=%0d got %b want %b", n, frame_valid, c); end
         n_checks++;
         if ({d3, d2, d1, d0} !== {exp_d[3], exp_d[2], exp_d[1], exp_d[0]}) begin
            n_fail++; $display("FAIL rand_digits n=%0d got %h want %h", n, {d3, d2, d1, d0},
                               {exp_d[3], exp_d[2], exp_d[1], exp_d[0]});
         end
         n_checks++;
         if ({sinal, pat_err, sel_err} !== {exp_sign, exp_perr, m_sel_err}) begin
            n_fail++; $display("FAIL rand_flags n=%0d got %b want %b", n, {sinal, pat_err, sel_err},
                               {exp_sign, exp_perr, m_sel_err});
         end
         if ($urandom_range(0, 3) == 0) @(negedge clk);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_basic();
      test_sign();
      test_pat_err();
      test_overwrite_sel();
      test_stale();
      test_reset_mid();
      test_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
